// File: rtl/handshake_slice.sv
// handshake_slice: valid/ready register slice with three timing modes.
//   MODE 0  forward  : valid/data registered, ready combinational.
//   MODE 1  backward : ready registered, one-entry skid buffer, zero latency.
//   MODE 2  full     : both directions registered, two-entry circular buffer.
// An optional checker flags an upstream that withdraws valid or changes data
// while stalled; the flag is sticky until reset.
//
// Ports:
//   clk      clock, rising edge
//   rstn     asynchronous active-low reset
//   valid_i  upstream valid            ready_o  ready to upstream
//   data_i   upstream payload [WIDTH]  data_o   downstream payload [WIDTH]
//   valid_o  valid to downstream       ready_i  downstream ready
//   count_o  entries currently held (0..2)
//   err_o    sticky upstream protocol violation
module handshake_slice #(
  parameter int WIDTH    = 32,
  parameter int MODE     = 2,
  parameter int CHECK_EN = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o,
  output logic             err_o
);

  generate
    if (MODE == 0) begin : g_fwd
      logic             vld_q;
      logic [WIDTH-1:0] dat_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (valid_i && ready_o) begin
          vld_q <= 1'b1;
          dat_q <= data_i;
        end else if (ready_i) begin
          vld_q <= 1'b0;
        end
      end

      // Accept when empty or when the held word leaves this cycle.
      assign ready_o = ~vld_q | ready_i;
      assign valid_o = vld_q;
      assign data_o  = dat_q;
      assign count_o = {1'b0, vld_q};

    end else if (MODE == 1) begin : g_skid
      logic             skid_vld;
      logic             rdy_q;
      logic [WIDTH-1:0] skid_dat;
      logic             capture;

      // Word accepted upstream that downstream cannot take this cycle.
      assign capture = valid_i & rdy_q & ~ready_i;

      // rdy_q tracks ~skid_vld but lives in its own flop so ready_o has no
      // combinational path from ready_i.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
          skid_dat <= '0;
        end else if (skid_vld) begin
          if (ready_i) begin
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
          end
        end else if (capture) begin
          skid_vld <= 1'b1;
          rdy_q    <= 1'b0;
          skid_dat <= data_i;
        end
      end

      assign ready_o = rdy_q;
      assign valid_o = valid_i | skid_vld;
      // Pass-through is zeroed when nothing is valid so idle data_o reads 0.
      assign data_o  = skid_vld ? skid_dat : (valid_i ? data_i : '0);
      assign count_o = {1'b0, skid_vld};

    end else begin : g_full
      logic [1:0][WIDTH-1:0] mem, mem_n;
      logic                  wr_ptr, rd_ptr, rd_n;
      logic [1:0]            cnt, cnt_n;
      logic                  vld_q, rdy_q;
      logic [WIDTH-1:0]      dat_q;
      logic                  push, pop;

      assign push = valid_i & rdy_q;
      assign pop  = vld_q & ready_i;
      assign rd_n = rd_ptr ^ pop;

      always_comb begin
        mem_n = mem;
        if (push) mem_n[wr_ptr] = data_i;
        cnt_n = cnt;
        case ({push, pop})
          2'b10:   cnt_n = cnt + 2'd1;
          2'b01:   cnt_n = cnt - 2'd1;
          default: ;
        endcase
      end

      // All outputs come from next-state values so they are plain flops.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          mem    <= '0;
          wr_ptr <= 1'b0;
          rd_ptr <= 1'b0;
          cnt    <= 2'd0;
          vld_q  <= 1'b0;
          rdy_q  <= 1'b1;
          dat_q  <= '0;
        end else begin
          mem    <= mem_n;
          wr_ptr <= wr_ptr ^ push;
          rd_ptr <= rd_n;
          cnt    <= cnt_n;
          vld_q  <= (cnt_n != 2'd0);
          rdy_q  <= (cnt_n != 2'd2);
          // When empty, data_o keeps the last delivered word.
          if (cnt_n != 2'd0) dat_q <= mem_n[rd_n];
        end
      end

      assign ready_o = rdy_q;
      assign valid_o = vld_q;
      assign data_o  = dat_q;
      assign count_o = cnt;
    end
  endgenerate

  generate
    if (CHECK_EN != 0) begin : g_chk
      logic             stall_q;
      logic [WIDTH-1:0] prev_q;
      logic             err_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          stall_q <= 1'b0;
          prev_q  <= '0;
          err_q   <= 1'b0;
        end else begin
          // A stalled offer must stay valid with identical data.
          if (stall_q && (!valid_i || (data_i != prev_q))) err_q <= 1'b1;
          stall_q <= valid_i & ~ready_o;
          prev_q  <= data_i;
        end
      end

      assign err_o = err_q;
    end else begin : g_nochk
      assign err_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_handshake_slice.sv
module tb_handshake_slice;

  logic            clk, rstn, valid_i, ready_i;
  logic [7:0]      data_i;
  logic [3:0]      rdy, vo, er;
  logic [3:0][7:0] dout;
  logic [3:0][1:0] cnt;

  int checks = 0;
  int failures = 0;

  // Instance i: MODE mode_of[i], checker chk_of[i]
  int mode_of[4] = '{0, 1, 2, 2};
  int chk_of[4]  = '{1, 1, 1, 0};

  handshake_slice #(.WIDTH(8), .MODE(0), .CHECK_EN(1)) u_m0 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(rdy[0]), .valid_o(vo[0]),
    .ready_i(ready_i), .data_i(data_i), .data_o(dout[0]), .count_o(cnt[0]), .err_o(er[0]));
  handshake_slice #(.WIDTH(8), .MODE(1), .CHECK_EN(1)) u_m1 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(rdy[1]), .valid_o(vo[1]),
    .ready_i(ready_i), .data_i(data_i), .data_o(dout[1]), .count_o(cnt[1]), .err_o(er[1]));
  handshake_slice #(.WIDTH(8), .MODE(2), .CHECK_EN(1)) u_m2 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(rdy[2]), .valid_o(vo[2]),
    .ready_i(ready_i), .data_i(data_i), .data_o(dout[2]), .count_o(cnt[2]), .err_o(er[2]));
  handshake_slice #(.WIDTH(8), .MODE(2), .CHECK_EN(0)) u_m2n (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(rdy[3]), .valid_o(vo[3]),
    .ready_i(ready_i), .data_i(data_i), .data_o(dout[3]), .count_o(cnt[3]), .err_o(er[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: a FIFO of held words per instance
  int         qn[4];
  logic [7:0] q0[4], q1[4], last[4], pd[4];
  logic       ps[4], me[4];

  function automatic void m_reset(input int i);
    qn[i] = 0; q0[i] = 8'h00; q1[i] = 8'h00; last[i] = 8'h00;
    pd[i] = 8'h00; ps[i] = 1'b0; me[i] = 1'b0;
  endfunction

  function automatic void m_push(input int i, input logic [7:0] d);
    if (qn[i] == 0) q0[i] = d; else q1[i] = d;
    qn[i]++;
  endfunction

  function automatic void m_pop(input int i);
    q0[i] = q1[i];
    qn[i]--;
  endfunction

  function automatic void m_expect(input int i, output logic r, output logic v,
                                   output logic [7:0] d, output logic [1:0] c);
    c = 2'(qn[i]);
    case (mode_of[i])
      0: begin r = (qn[i] == 0) || ready_i; v = qn[i] > 0; d = q0[i]; end
      1: begin r = (qn[i] == 0); v = (qn[i] > 0) || valid_i;
               d = (qn[i] > 0) ? q0[i] : data_i; end
      default: begin r = qn[i] < 2; v = qn[i] > 0; d = last[i]; end
    endcase
  endfunction

  function automatic void m_step(input int i, input logic r, input logic v);
    logic tin, tout;
    tin  = valid_i & r;
    tout = v & ready_i;
    if (chk_of[i] != 0) begin
      if (ps[i] && (!valid_i || data_i != pd[i])) me[i] = 1'b1;
      ps[i] = valid_i & ~r;
      pd[i] = data_i;
    end
    case (mode_of[i])
      1: begin
        if (qn[i] > 0) begin
          if (ready_i) m_pop(i);
        end else if (valid_i && !ready_i) m_push(i, data_i);
      end
      default: begin
        if (tout) m_pop(i);
        if (tin) m_push(i, data_i);
        if (mode_of[i] == 2 && qn[i] > 0) last[i] = q0[i];
      end
    endcase
  endfunction

  // Compare every instance against the model on each falling edge, then
  // advance the model with the inputs the coming rising edge will sample.
  initial begin
    for (int i = 0; i < 4; i++) m_reset(i);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        logic r, v;
        logic [7:0] d, da;
        logic [1:0] c;
        if (!rstn) m_reset(i);
        m_expect(i, r, v, d, c);
        if (!(v || mode_of[i] == 2)) d = 8'h00;
        da = (v || mode_of[i] == 2) ? dout[i] : 8'h00;
        checks++;
        if ({rdy[i], vo[i], cnt[i], er[i], da} !== {r, v, c, me[i], d}) begin
          failures++;
          $display("FAIL model_inst%0d t=%0t got r/v/c/e/d=%b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h",
                   i, $time, rdy[i], vo[i], cnt[i], er[i], da, r, v, c, me[i], d);
        end
        if (rstn) m_step(i, r, v);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations
  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic r);
    valid_i = v; data_i = d; ready_i = r;
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    drv(1'b0, 8'h55, 1'b0);
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    drv(1'b0, 8'h55, 1'b0);
    #1 rstn = 1'b0;
    #7 rstn = 1'b1;
    #1;
    lit("rst_valid", {4'b0, vo}, 8'h00);
    lit("rst_ready", {4'b0, rdy}, 8'h0F);
    lit("rst_err", {4'b0, er}, 8'h00);
    lit("rst_count", {cnt[3], cnt[2], cnt[1], cnt[0]}, 8'h00);
    for (int i = 0; i < 4; i++) lit("rst_data", dout[i], 8'h00);

    // Streaming 1..4 with ready_i high
    tick();
    drv(1'b1, 8'd1, 1'b1);
    #1;
    lit("strm_m1_same_cycle", dout[1], 8'd1);
    lit("strm_m0_not_yet", {7'b0, vo[0]}, 8'd0);
    tick();
    lit("strm_m0_lat1", dout[0], 8'd1);
    lit("strm_m2_lat1", dout[2], 8'd1);
    drv(1'b1, 8'd2, 1'b1);
    #1;
    lit("strm_m1_word2", dout[1], 8'd2);
    tick();
    lit("strm_m2_word2", dout[2], 8'd2);
    drv(1'b1, 8'd3, 1'b1);
    tick();
    drv(1'b1, 8'd4, 1'b1);
    tick();
    drv(1'b0, 8'd4, 1'b1);
    lit("strm_m2_word4", dout[2], 8'd4);
    lit("strm_m2_count", {6'b0, cnt[2]}, 8'd1);
    tick();
    lit("strm_m2_empty_valid", {7'b0, vo[2]}, 8'd0);
    lit("strm_m2_empty_hold", dout[2], 8'd4);

    // Backpressure on the full slice: 5,6,7 with ready_i low
    do_reset();
    drv(1'b1, 8'd5, 1'b0);
    tick();
    lit("bp_cnt1", {6'b0, cnt[2]}, 8'd1);
    lit("bp_head5", dout[2], 8'd5);
    drv(1'b1, 8'd6, 1'b0);
    tick();
    lit("bp_cnt2", {6'b0, cnt[2]}, 8'd2);
    lit("bp_ready_low", {7'b0, rdy[2]}, 8'd0);
    drv(1'b1, 8'd7, 1'b0);
    tick();
    lit("bp_7_held", {6'b0, cnt[2]}, 8'd2);
    drv(1'b1, 8'd7, 1'b1);
    tick();
    lit("bp_out6", dout[2], 8'd6);
    lit("bp_cnt_after5", {6'b0, cnt[2]}, 8'd1);
    tick();
    lit("bp_out7", dout[2], 8'd7);
    drv(1'b0, 8'd7, 1'b1);
    tick();
    lit("bp_drained", {6'b0, cnt[2]}, 8'd0);

    // Skid capture on the backward slice
    do_reset();
    drv(1'b1, 8'h0A, 1'b0);
    #1;
    lit("skid_pass_A", dout[1], 8'h0A);
    tick();
    lit("skid_ready_low", {7'b0, rdy[1]}, 8'd0);
    lit("skid_valid_kept", {7'b0, vo[1]}, 8'd1);
    lit("skid_holds_A", dout[1], 8'h0A);
    drv(1'b1, 8'h0B, 1'b0);
    tick();
    lit("skid_still_A", dout[1], 8'h0A);
    drv(1'b1, 8'h0B, 1'b1);
    tick();
    lit("skid_ready_back", {7'b0, rdy[1]}, 8'd1);
    lit("skid_then_B", dout[1], 8'h0B);
    tick();
    drv(1'b0, 8'h00, 1'b1);
    #1;
    lit("skid_idle", {7'b0, vo[1]}, 8'd0);

    // Simultaneous in/out at count 1, four words across pointer wrap
    do_reset();
    drv(1'b1, 8'h10, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 8'(8'h11 + k), 1'b1);
      tick();
      lit("sim_cnt", {6'b0, cnt[2]}, 8'd1);
      lit("sim_data", dout[2], 8'(8'h11 + k));
    end
    drv(1'b0, 8'h00, 1'b1);
    tick();
    lit("sim_drained", {6'b0, cnt[2]}, 8'd0);

    // Data changed while stalled
    do_reset();
    drv(1'b1, 8'd1, 1'b0);
    tick();
    drv(1'b1, 8'd2, 1'b0);
    tick();
    lit("err_stall", {7'b0, rdy[2]}, 8'd0);
    drv(1'b1, 8'd3, 1'b0);
    tick();
    lit("err_not_yet", {7'b0, er[2]}, 8'd0);
    drv(1'b1, 8'd4, 1'b0);
    tick();
    lit("err_set", {7'b0, er[2]}, 8'd1);
    lit("err_disabled", {7'b0, er[3]}, 8'd0);
    drv(1'b0, 8'd0, 1'b1);
    tick();
    tick();
    lit("err_sticky", {7'b0, er[2]}, 8'd1);
    rstn = 1'b0;
    #1;
    lit("err_cleared", {4'b0, er}, 8'd0);
    tick();
    rstn = 1'b1;

    // Valid withdrawn while stalled (forward slice)
    drv(1'b1, 8'd7, 1'b0);
    tick();
    drv(1'b1, 8'd8, 1'b0);
    tick();
    drv(1'b0, 8'd8, 1'b0);
    tick();
    lit("err_withdraw", {7'b0, er[0]}, 8'd1);
    drv(1'b0, 8'd0, 1'b1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
